rle_ctrl: RTL and testbench

RLE_CTRL -- requirements
Module: rle_ctrl

---
 rtl/rle_ctrl.sv | 93 +++++++++
 tb/tb_rle_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_ctrl.sv
// Run-length encoder: turns a stream of symbols into (symbol, count) pairs,
// one packet at a time, behind a single-entry output register with valid/ready.
module rle_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] MAX_RUN = '1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] sym;
  logic [CNT_W-1:0]  cnt;

  logic out_free;
  logic accept;
  logic split;
  logic emit_run;
  logic emit_final;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = in_last ? FLUSH : RUN;
      RUN:     if (accept) state_next = in_last ? FLUSH : RUN;
      FLUSH:   if (out_free) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and emission decisions
  always_comb begin
    out_free   = !out_valid | out_ready;
    in_ready   = !reset & (state != FLUSH) & out_free;
    accept     = in_valid & in_ready;
    split      = (in_data != sym) | (cnt == MAX_RUN);
    emit_run   = (state == RUN) & accept & split;
    emit_final = (state == FLUSH) & out_free;
  end

  // Active run: a new packet or a split always restarts at count 1
  always_ff @(posedge clock) begin
    if (reset) begin
      sym <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (state == RUN && !split) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        sym <= in_data;
        cnt <= CNT_W'(1);
      end
    end
  end

  // Output register; a load during a handshake replaces the pair with no bubble
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else if (emit_run || emit_final) begin
      out_valid <= 1'b1;
      out_data  <= sym;
      out_count <= cnt;
      out_last  <= emit_final;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rle_ctrl.sv
// Self-checking bench for rle_ctrl: directed scenarios plus randomized packets
// checked against a list-based run-length model and an output scoreboard.
module tb_rle_ctrl;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int MAX    = 15;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] c;
    logic       l;
  } pair_t;

  logic              clock = 0;
  logic              reset = 1;
  logic              in_valid = 0;
  logic [DATA_W-1:0] in_data = 0;
  logic              in_last = 0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_last;
  logic              out_ready = 1;

  int    tests = 0;
  int    fails = 0;
  int    rmode = 0;
  pair_t exp_q[$];

  rle_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
    .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int waits = 0;
    in_valid = 1;
    in_data  = d;
    in_last  = l;
    @(negedge clock);
    while (!in_ready && waits < 300) begin
      @(negedge clock);
      waits++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic exp_push(input logic [7:0] d, input int c, input logic l);
    pair_t p;
    p.d = d;
    p.c = 4'(c);
    p.l = l;
    exp_q.push_back(p);
  endtask

  // Reference: walk the packet as a list, closing a run on a new symbol or at MAX
  task automatic model_packet(input logic [7:0] s[$]);
    logic [7:0] cur;
    int n;
    cur = s[0];
    n = 1;
    for (int i = 1; i < s.size(); i++) begin
      if (s[i] == cur && n < MAX) n++;
      else begin
        exp_push(cur, n, 1'b0);
        cur = s[i];
        n = 1;
      end
    end
    exp_push(cur, n, 1'b1);
  endtask

  task automatic send_packet(input logic [7:0] s[$], input int max_gap);
    for (int i = 0; i < s.size(); i++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send(s[i], i == s.size() - 1);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      idle(1);
      t++;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    case (rmode)
      0:       out_ready = 1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 0;
    endcase
  end

  // Scoreboard and hold-stability monitor
  initial begin
    logic [12:0] hold_val;
    logic        stall_prev;
    pair_t       e;
    stall_prev = 0;
    hold_val = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (stall_prev) begin
          check("hold_valid", out_valid, 1);
          check("hold_pair", {out_data, out_count, out_last}, hold_val);
        end
        if (out_valid && out_ready) begin
          $display("[TB] pair data=0x%02h count=%0d last=%0d", out_data, out_count, out_last);
          if (exp_q.size() == 0) check("unexpected_pair", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("pair_data", out_data, e.d);
            check("pair_count", out_count, e.c);
            check("pair_last", out_last, e.l);
          end
        end
        stall_prev = out_valid && !out_ready;
        hold_val = {out_data, out_count, out_last};
      end else begin
        stall_prev = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    int len;
    logic [7:0] cur;

    // Reset state
    idle(2);
    @(negedge clock);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_last", out_last, 0);
    @(posedge clock);
    #1;
    reset = 0;
    @(negedge clock);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clock);
    #1;

    // A,A,A,B(last)
    rmode = 0;
    exp_push(8'h41, 3, 0);
    exp_push(8'h42, 1, 1);
    s = '{8'h41, 8'h41, 8'h41, 8'h42};
    send_packet(s, 0);
    drain();

    // 17 x A: run saturates at MAX
    exp_push(8'h41, 15, 0);
    exp_push(8'h41, 2, 1);
    s = {};
    for (int i = 0; i < 17; i++) s.push_back(8'h41);
    send_packet(s, 0);
    drain();

    // Single beat with last: FLUSH blocks input, pair two edges after accept
    exp_push(8'h07, 1, 1);
    send(8'h07, 1);
    @(negedge clock);
    check("flush_in_ready", in_ready, 0);
    check("flush_out_valid", out_valid, 0);
    idle(1);
    @(negedge clock);
    check("single_out_valid", out_valid, 1);
    check("single_out_data", out_data, 8'h07);
    idle(1);
    drain();

    // Backpressure: output stalls, input blocked, then release
    rmode = 2;
    idle(2);
    exp_push(8'h41, 1, 0);
    exp_push(8'h42, 1, 0);
    exp_push(8'h43, 1, 0);
    exp_push(8'h44, 1, 1);
    s = '{8'h41, 8'h42, 8'h43, 8'h44};
    fork
      send_packet(s, 0);
      begin
        idle(6);
        @(negedge clock);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", out_data, 8'h41);
        idle(1);
        rmode = 0;
      end
    join
    drain();

    // Reset mid-run discards the run
    s = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    for (int i = 0; i < 5; i++) send(s[i], 0);
    reset = 1;
    @(negedge clock);
    check("midrst_in_ready", in_ready, 0);
    idle(1);
    @(negedge clock);
    check("midrst_out_valid", out_valid, 0);
    idle(1);
    reset = 0;
    @(negedge clock);
    check("midrst_release_in_ready", in_ready, 1);
    check("midrst_no_pair", out_valid, 0);
    idle(1);
    exp_push(8'h22, 1, 1);
    send(8'h22, 1);
    drain();

    // Input gaps do not break a run
    exp_push(8'h41, 2, 0);
    exp_push(8'h42, 1, 1);
    send(8'h41, 0);
    idle(3);
    send(8'h41, 0);
    idle(3);
    send(8'h42, 1);
    drain();

    // Randomized packets with random gaps and out_ready patterns
    for (int p = 0; p < 30; p++) begin
      rmode = $urandom_range(0, 1);
      len = $urandom_range(1, 40);
      s = {};
      cur = 8'($urandom_range(0, 2));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) cur = 8'($urandom_range(0, 2));
        s.push_back(cur);
      end
      model_packet(s);
      send_packet(s, (p % 3 == 0) ? 2 : 0);
    end
    rmode = 0;
    drain();
    idle(3);
    check("final_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
